// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between the MIPS
// core (port C) and the debug/program loader (port D), one transaction at a time.
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int N       = 64,
    parameter int MEM_LAT = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         c_req,
    input  logic [N-1:0] c_adr,
    input  logic [N-1:0] c_wdata,
    input  logic [1:0]   c_memwrite,
    input  logic         c_dtype,
    output logic [N-1:0] c_rdata,
    output logic         c_ack,
    input  logic         d_req,
    input  logic [N-1:0] d_adr,
    input  logic [N-1:0] d_wdata,
    input  logic [1:0]   d_memwrite,
    input  logic         d_dtype,
    output logic [N-1:0] d_rdata,
    output logic         d_ack,
    output logic         m_en,
    output logic [N-1:0] m_adr,
    output logic [N-1:0] m_wdata,
    output logic [1:0]   m_memwrite,
    output logic         m_dtype,
    input  logic [N-1:0] m_rdata,
    output logic         busy,
    output logic         owner
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam int WCW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    state_t         state, next_state;
    logic [WCW-1:0] waitcount;
    logic [1:0]     mw_q;
    logic           last;
    logic           any_req;
    logic           grant_d;
    logic           is_read;
    logic [N-1:0]   c_rd_q, d_rd_q;

    assign any_req = c_req | d_req;
    // Debug wins when alone, or on a tie when the core was the last one served.
    assign grant_d = d_req & (~c_req | ~last);
    assign is_read = (mw_q == 2'b00);

    // NOTE: sequential state is always assigned with <= so every flop samples
    // pre-edge values; a blocking = here would create ordering-dependent logic.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_req) next_state = ISSUE;
            ISSUE:   next_state = (MEM_LAT > 1) ? WAIT : RESP;
            WAIT:    if (waitcount == WCW'(1)) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_adr     <= '0;
            m_wdata   <= '0;
            m_dtype   <= 1'b0;
            mw_q      <= 2'b00;
            owner     <= 1'b0;
            last      <= 1'b1;
            waitcount <= '0;
            c_rd_q    <= '0;
            d_rd_q    <= '0;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    m_adr   <= grant_d ? d_adr      : c_adr;
                    m_wdata <= grant_d ? d_wdata    : c_wdata;
                    m_dtype <= grant_d ? d_dtype    : c_dtype;
                    mw_q    <= grant_d ? d_memwrite : c_memwrite;
                    owner   <= grant_d;
                    last    <= grant_d;
                end
                ISSUE: waitcount <= WCW'(MEM_LAT - 1);
                WAIT:  waitcount <= waitcount - WCW'(1);
                RESP: if (is_read) begin
                    if (owner) d_rd_q <= m_rdata;
                    else       c_rd_q <= m_rdata;
                end
                default: ;
            endcase
        end
    end

    // Read data is forwarded in the ack cycle and held by the registers afterwards.
    always_comb begin
        m_en       = 1'b0;
        m_memwrite = 2'b00;
        c_ack      = 1'b0;
        d_ack      = 1'b0;
        busy       = (state != IDLE);
        c_rdata    = c_rd_q;
        d_rdata    = d_rd_q;
        case (state)
            ISSUE: begin
                m_en       = 1'b1;
                m_memwrite = mw_q;
            end
            RESP: begin
                c_ack = ~owner;
                d_ack = owner;
                if (is_read) begin
                    if (owner) d_rdata = m_rdata;
                    else       c_rdata = m_rdata;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: one instance at MEM_LAT=1 checked by a
// monitor against queued expectations, one at MEM_LAT=3 for latency/abort cases.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int N = 64;
    localparam logic [N-1:0] NOISE = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    logic         c_req, c_dtype, d_req, d_dtype;
    logic [N-1:0] c_adr, c_wdata, d_adr, d_wdata;
    logic [1:0]   c_memwrite, d_memwrite;
    logic [N-1:0] c_rdata, d_rdata, m_adr, m_wdata, m_rdata;
    logic         c_ack, d_ack, m_en, m_dtype, busy, owner;
    logic [1:0]   m_memwrite;

    logic         c3_req, c3_dtype, d3_req, d3_dtype;
    logic [N-1:0] c3_adr, c3_wdata, d3_adr, d3_wdata;
    logic [1:0]   c3_memwrite, d3_memwrite;
    logic [N-1:0] c3_rdata, d3_rdata, m3_adr, m3_wdata, m3_rdata;
    logic         c3_ack, d3_ack, m3_en, m3_dtype, busy3, owner3;
    logic [1:0]   m3_memwrite;

    mem_arbiter #(.N(N), .MEM_LAT(1)) dut (
        .clk(clk), .reset(rst_n),
        .c_req(c_req), .c_adr(c_adr), .c_wdata(c_wdata), .c_memwrite(c_memwrite),
        .c_dtype(c_dtype), .c_rdata(c_rdata), .c_ack(c_ack),
        .d_req(d_req), .d_adr(d_adr), .d_wdata(d_wdata), .d_memwrite(d_memwrite),
        .d_dtype(d_dtype), .d_rdata(d_rdata), .d_ack(d_ack),
        .m_en(m_en), .m_adr(m_adr), .m_wdata(m_wdata), .m_memwrite(m_memwrite),
        .m_dtype(m_dtype), .m_rdata(m_rdata), .busy(busy), .owner(owner)
    );

    mem_arbiter #(.N(N), .MEM_LAT(3)) dut3 (
        .clk(clk), .reset(rst_n),
        .c_req(c3_req), .c_adr(c3_adr), .c_wdata(c3_wdata), .c_memwrite(c3_memwrite),
        .c_dtype(c3_dtype), .c_rdata(c3_rdata), .c_ack(c3_ack),
        .d_req(d3_req), .d_adr(d3_adr), .d_wdata(d3_wdata), .d_memwrite(d3_memwrite),
        .d_dtype(d3_dtype), .d_rdata(d3_rdata), .d_ack(d3_ack),
        .m_en(m3_en), .m_adr(m3_adr), .m_wdata(m3_wdata), .m_memwrite(m3_memwrite),
        .m_dtype(m3_dtype), .m_rdata(m3_rdata), .busy(busy3), .owner(owner3)
    );

    // Memory models: read data appears exactly MEM_LAT cycles after m_en, noise otherwise.
    logic [N-1:0] mem1 [logic [N-1:0]];
    logic [N-1:0] mem3 [logic [N-1:0]];
    logic [N-1:0] p3 [3];

    function automatic logic [N-1:0] rd1(input logic [N-1:0] a);
        return mem1.exists(a) ? mem1[a] : 64'hBAD0_0000_0000_0000;
    endfunction

    function automatic logic [N-1:0] rd3(input logic [N-1:0] a);
        return mem3.exists(a) ? mem3[a] : 64'hBAD3_0000_0000_0000;
    endfunction

    always @(posedge clk) begin
        if (m_en && m_memwrite != 2'b00) mem1[m_adr] = m_wdata;
        m_rdata <= (m_en && m_memwrite == 2'b00) ? rd1(m_adr) : NOISE;
    end

    always @(posedge clk) begin
        if (m3_en && m3_memwrite != 2'b00) mem3[m3_adr] = m3_wdata;
        p3[0] <= (m3_en && m3_memwrite == 2'b00) ? rd3(m3_adr) : NOISE;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign m3_rdata = p3[2];

    typedef struct {
        bit           port;
        bit           is_wr;
        logic [N-1:0] rdata;
    } ack_exp_t;

    typedef struct {
        logic [N-1:0] adr;
        logic [1:0]   mw;
        logic [N-1:0] wdata;
    } iss_exp_t;

    ack_exp_t ack_q[$];
    iss_exp_t iss_q[$];
    int       men_times[$];
    ack_exp_t ack_e;
    iss_exp_t iss_e;
    logic [N-1:0] mdl_c, mdl_d;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor for the MEM_LAT=1 instance: pops expectations on every m_en and ack.
    always @(negedge clk) begin
        if (!rst_n) begin
            mdl_c = '0;
            mdl_d = '0;
        end else begin
            if (m_en) begin
                men_times.push_back(cyc);
                check("issue_expected", N'(iss_q.size() != 0), N'(1));
                if (iss_q.size() != 0) begin
                    iss_e = iss_q.pop_front();
                    check("m_adr", m_adr, iss_e.adr);
                    check("m_memwrite", N'(m_memwrite), N'(iss_e.mw));
                    if (iss_e.mw != 2'b00) check("m_wdata", m_wdata, iss_e.wdata);
                end
            end else begin
                check("m_memwrite_idle", N'(m_memwrite), N'(0));
            end
            if (c_ack || d_ack) begin
                check("ack_exclusive", N'(c_ack && d_ack), N'(0));
                check("ack_expected", N'(ack_q.size() != 0), N'(1));
                if (ack_q.size() != 0) begin
                    ack_e = ack_q.pop_front();
                    check("ack_port", N'(d_ack), N'(ack_e.port));
                    check("owner_at_ack", N'(owner), N'(ack_e.port));
                    if (!ack_e.is_wr) begin
                        if (ack_e.port) mdl_d = ack_e.rdata;
                        else            mdl_c = ack_e.rdata;
                    end
                end
            end
            check("c_rdata", c_rdata, mdl_c);
            check("d_rdata", d_rdata, mdl_d);
        end
    end

    // which: 0 c_ack, 1 d_ack, 2 c3_ack, 3 d3_ack, 4 c_ack|d_ack, other m3_en
    task automatic wait_sig(input int which, input string name, output int at);
        logic hit;
        at = -1;
        for (int i = 0; i < 40 && at < 0; i++) begin
            @(negedge clk);
            case (which)
                0:       hit = c_ack;
                1:       hit = d_ack;
                2:       hit = c3_ack;
                3:       hit = d3_ack;
                4:       hit = c_ack | d_ack;
                default: hit = m3_en;
            endcase
            if (hit) at = cyc;
        end
        check({name, "_seen"}, N'(at >= 0), N'(1));
    endtask

    task automatic txn(input bit port, input logic [N-1:0] adr, input logic [N-1:0] wdata,
                       input logic [1:0] mw, input logic [N-1:0] exp_rd,
                       output int t0, output int at);
        if (port) begin
            d_adr = adr; d_wdata = wdata; d_memwrite = mw; d_req = 1'b1;
        end else begin
            c_adr = adr; c_wdata = wdata; c_memwrite = mw; c_req = 1'b1;
        end
        ack_q.push_back('{port, mw != 2'b00, exp_rd});
        iss_q.push_back('{adr, mw, wdata});
        t0 = cyc;
        wait_sig(port ? 1 : 0, port ? "d_ack" : "c_ack", at);
        if (port) d_req = 1'b0;
        else      c_req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, at, bad;

        mem1[64'h40] = 64'h1234;
        mem1[64'h48] = 64'h5555;
        mem1[64'h50] = 64'h6666;
        mem1[64'h58] = 64'h7777;
        mem3[64'h10] = 64'hABCD;
        mem3[64'h20] = 64'h2222;

        c_req = 0; c_adr = '0; c_wdata = '0; c_memwrite = 2'b00; c_dtype = 0;
        d_req = 0; d_adr = '0; d_wdata = '0; d_memwrite = 2'b00; d_dtype = 0;
        c3_req = 0; c3_adr = '0; c3_wdata = '0; c3_memwrite = 2'b00; c3_dtype = 0;
        d3_req = 0; d3_adr = '0; d3_wdata = '0; d3_memwrite = 2'b00; d3_dtype = 0;
        rst_n = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_busy", N'(busy), N'(0));
        check("rst_m_en", N'(m_en), N'(0));
        check("rst_owner", N'(owner), N'(0));
        check("rst_m_memwrite", N'(m_memwrite), N'(0));
        check("rst_acks", N'({c_ack, d_ack}), N'(0));
        check("rst_m_adr", m_adr, N'(0));
        check("rst_c_rdata", c_rdata, N'(0));
        check("rst_busy3", N'(busy3), N'(0));
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Single core read: m_en one cycle after the IDLE sample, ack one later.
        men_times.delete();
        txn(1'b0, 64'h40, 64'h0, 2'b00, 64'h1234, t0, at);
        check("t1_ack_cycle", N'(at), N'(t0 + 2));
        check("t1_m_en_cycle", N'(men_times.size() > 0 ? men_times[0] : -1), N'(t0 + 1));
        repeat (2) @(negedge clk);
        check("t1_c_rdata_held", c_rdata, 64'h1234);

        // Simultaneous first requests after reset: core first, then debug.
        do_reset();
        c_adr = 64'h48; c_memwrite = 2'b00;
        d_adr = 64'h50; d_memwrite = 2'b00;
        ack_q.push_back('{1'b0, 1'b0, 64'h5555});
        ack_q.push_back('{1'b1, 1'b0, 64'h6666});
        iss_q.push_back('{64'h48, 2'b00, 64'h0});
        iss_q.push_back('{64'h50, 2'b00, 64'h0});
        c_req = 1; d_req = 1;
        wait_sig(0, "t2_c_ack", at);
        c_req = 0;
        wait_sig(1, "t2_d_ack", at);
        check("t2_owner_debug", N'(owner), N'(1));
        d_req = 0;

        // Both requesting continuously: strict c,d,c,d with m_en every 3 cycles.
        c_adr = 64'h40; d_adr = 64'h58;
        men_times.delete();
        for (int k = 0; k < 4; k++) begin
            ack_q.push_back('{k[0], 1'b0, k[0] ? 64'h7777 : 64'h1234});
            iss_q.push_back('{k[0] ? 64'h58 : 64'h40, 2'b00, 64'h0});
        end
        c_req = 1; d_req = 1;
        for (int k = 0; k < 4; k++) wait_sig(4, "t3_ack", at);
        c_req = 0; d_req = 0;
        check("t3_m_en_count", N'(men_times.size()), N'(4));
        for (int k = 1; k < men_times.size(); k++)
            check("t3_m_en_spacing", N'(men_times[k] - men_times[k-1]), N'(3));

        // Writes: one-cycle m_memwrite, rdata untouched, then read back.
        txn(1'b1, 64'h80, 64'hDEAD, 2'b10, 64'h0, t0, at);
        check("t4_d_rdata_kept", d_rdata, 64'h7777);
        check("t4_c_rdata_kept", c_rdata, 64'h1234);
        txn(1'b0, 64'h88, 64'h55, 2'b01, 64'h0, t0, at);
        txn(1'b0, 64'h80, 64'h0, 2'b00, 64'hDEAD, t0, at);
        txn(1'b1, 64'h88, 64'h0, 2'b00, 64'h55, t0, at);

        // MEM_LAT=3 core read: busy for 4 cycles, ack in the 4th.
        @(negedge clk);
        c3_adr = 64'h10; c3_memwrite = 2'b00; c3_req = 1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check("t5_busy", N'(busy3), N'(k <= 4));
            check("t5_ack", N'(c3_ack), N'(k == 4));
            if (k == 1) check("t5_m_en", N'(m3_en), N'(1));
            if (k == 4) begin
                check("t5_rdata", c3_rdata, 64'hABCD);
                c3_req = 0;
            end
        end
        check("t5_rdata_held", c3_rdata, 64'hABCD);

        // Reset during WAIT aborts the transaction with no ack.
        c3_req = 1;
        @(negedge clk);
        check("t6_issue", N'(m3_en), N'(1));
        @(negedge clk);
        check("t6_wait", N'({busy3, m3_en}), N'(2'b10));
        #1 rst_n = 1'b0;
        c3_req = 0;
        #1;
        check("t6_abort_m_en", N'(m3_en), N'(0));
        check("t6_abort_memwrite", N'(m3_memwrite), N'(0));
        check("t6_abort_ack", N'(c3_ack), N'(0));
        check("t6_abort_busy", N'(busy3), N'(0));
        check("t6_abort_rdata", c3_rdata, N'(0));
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (c3_ack || d3_ack || busy3) bad = 1;
        end
        check("t6_no_ack_after_abort", N'(bad), N'(0));
        c3_adr = 64'h10; d3_adr = 64'h20;
        c3_req = 1; d3_req = 1;
        wait_sig(5, "t6_m_en", at);
        check("t6_owner_core", N'(owner3), N'(0));
        check("t6_m_adr_core", m3_adr, 64'h10);
        wait_sig(2, "t6_c_ack", at);
        c3_req = 0;
        check("t6_c_rdata", c3_rdata, 64'hABCD);
        wait_sig(3, "t6_d_ack", at);
        check("t6_owner_debug", N'(owner3), N'(1));
        check("t6_d_rdata", d3_rdata, 64'h2222);
        d3_req = 0;

        repeat (3) @(negedge clk);
        check("scoreboard_drained", N'(ack_q.size() + iss_q.size()), N'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
